// File: rtl/uart_prog_pkg.sv
// Shared types and constants for the UART programmer sequencer.
package uart_prog_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam logic [7:0] ACK_BYTE      = 8'h5A;
    localparam logic [7:0] NAK_BYTE      = 8'hEE;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/uart_prog_ctrl_axil_single_write.sv
// Single-outstanding AXI4-Lite write engine: launches AW and W together,
// lets each drop after its own handshake, then waits for B.
module axil_single_write
    import uart_prog_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
    output logic [2:0]            m_axil_awprot_o,
    output logic                  m_axil_awvalid_o,
    input  logic                  m_axil_awready_i,
    output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
    output logic [3:0]            m_axil_wstrb_o,
    output logic                  m_axil_wvalid_o,
    input  logic                  m_axil_wready_i,
    input  logic [1:0]            m_axil_bresp_i,
    input  logic                  m_axil_bvalid_i,
    output logic                  m_axil_bready_o
);

    logic                  r_busy;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_bready;
    logic                  w_retire;

    // B is only accepted once both address and data have been handed over.
    assign w_bready = r_busy & ~r_awvalid & ~r_wvalid;
    assign w_retire = w_bready & m_axil_bvalid_i;

    // Write channel sequencing; a new start may overlap the retiring cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy    <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else begin
            if (r_awvalid && m_axil_awready_i) r_awvalid <= 1'b0;
            if (r_wvalid && m_axil_wready_i)   r_wvalid  <= 1'b0;
            if (w_retire)                      r_busy    <= 1'b0;
            if (start_i && (!r_busy || w_retire)) begin
                r_busy    <= 1'b1;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= addr_i;
                r_wdata   <= data_i;
            end
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = w_retire;
    assign err_o            = w_retire & (m_axil_bresp_i != AXI_RESP_OKAY);
    assign m_axil_awaddr_o  = r_awaddr;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = r_awvalid;
    assign m_axil_wdata_o   = r_wdata;
    assign m_axil_wstrb_o   = 4'hF;
    assign m_axil_wvalid_o  = r_wvalid;
    assign m_axil_bready_o  = w_bready;

endmodule

// File: rtl/uart_prog_ctrl.sv
// UART programmer sequencer: parses sync/base/count/payload frames from the
// receiver, writes each payload word over AXI4-Lite and holds the core in
// reset until a load completes.
//
// state | meaning
// IDLE  | waiting for the sync byte, other bytes dropped
// ADDR  | collecting 4-byte little-endian base address
// LEN   | collecting 4-byte little-endian word count
// DATA  | collecting payload words, one AXI write per word
// DONE  | presenting ACK byte, core released on handshake
// ERROR | presenting NAK byte, core stays in reset
module uart_prog_ctrl
    import uart_prog_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr_o,
    output logic [2:0]            m_axil_awprot_o,
    output logic                  m_axil_awvalid_o,
    input  logic                  m_axil_awready_i,
    output logic [DATA_WIDTH-1:0] m_axil_wdata_o,
    output logic [3:0]            m_axil_wstrb_o,
    output logic                  m_axil_wvalid_o,
    input  logic                  m_axil_wready_i,
    input  logic [1:0]            m_axil_bresp_i,
    input  logic                  m_axil_bvalid_i,
    output logic                  m_axil_bready_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  error_o
);

    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [1:0]            r_byte_cnt;
    logic [31:0]           r_word;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_count;
    logic [31:0]           r_idx;
    logic [TMO_W-1:0]      r_tmo;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  r_core_rst;
    logic                  r_error;

    logic [31:0]           w_word_next;
    logic                  w_field_last;
    logic                  w_payload_open;
    logic                  w_word_done;
    logic                  w_overrun;
    logic                  w_tmo_run;
    logic                  w_tmo_expired;
    logic                  w_go_err;
    logic                  w_go_done;
    logic                  w_wr_start;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic                  w_wr_busy;
    logic                  w_wr_done;
    logic                  w_wr_err;

    assign w_word_next    = {rx_data_i, r_word[31:8]};
    assign w_field_last   = rx_valid_i && (r_byte_cnt == 2'd3);
    assign w_payload_open = (r_idx != r_count);
    assign w_word_done    = (r_state == DATA) && w_field_last && w_payload_open;
    assign w_overrun      = w_word_done && w_wr_busy && !w_wr_done;
    // Once every payload byte is in, only B is awaited; the timer pauses.
    assign w_tmo_run      = (r_state == ADDR) || (r_state == LEN) ||
                            ((r_state == DATA) && w_payload_open);
    assign w_tmo_expired  = w_tmo_run && !rx_valid_i && (r_tmo == '0);
    assign w_wr_addr      = r_base + ADDR_WIDTH'(r_idx << 2);
    assign w_wr_start     = w_word_done && !w_go_err;

    // Terminal conditions that end a frame, evaluated each cycle.
    always_comb begin
        w_go_err  = 1'b0;
        w_go_done = 1'b0;
        if ((r_state == ADDR) && w_field_last && (w_word_next[1:0] != 2'b00))
            w_go_err = 1'b1;
        if (w_tmo_expired || w_overrun)
            w_go_err = 1'b1;
        if ((r_state == DATA) && w_wr_done && w_wr_err)
            w_go_err = 1'b1;
        if ((r_state == LEN) && w_field_last && (w_word_next == 32'd0))
            w_go_done = 1'b1;
        if ((r_state == DATA) && w_wr_done && !w_wr_err && !w_payload_open)
            w_go_done = 1'b1;
    end

    // Frame FSM with byte assembly, timeout down-counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
            r_base     <= '0;
            r_count    <= 32'd0;
            r_idx      <= 32'd0;
            r_tmo      <= TMO_LOAD;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_core_rst <= 1'b1;
            r_error    <= 1'b0;
        end else begin
            if (w_tmo_run) begin
                if (rx_valid_i)
                    r_tmo <= TMO_LOAD;
                else if (r_tmo != '0)
                    r_tmo <= r_tmo - TMO_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                        r_state    <= ADDR;
                        r_core_rst <= 1'b1;
                        r_error    <= 1'b0;
                        r_byte_cnt <= 2'd0;
                        r_tmo      <= TMO_LOAD;
                    end
                end
                ADDR: begin
                    if (rx_valid_i) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_base  <= ADDR_WIDTH'(w_word_next);
                            r_state <= LEN;
                        end
                    end
                end
                LEN: begin
                    if (rx_valid_i) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_count <= w_word_next;
                            r_idx   <= 32'd0;
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid_i && w_payload_open) begin
                        r_word     <= w_word_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3)
                            r_idx <= r_idx + 32'd1;
                    end
                end
                DONE: begin
                    if (r_tx_valid && tx_ready_i) begin
                        r_tx_valid <= 1'b0;
                        r_core_rst <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                ERROR: begin
                    if (r_tx_valid && tx_ready_i) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Terminal transitions override the per-state updates above.
            if (w_go_err) begin
                r_state    <= ERROR;
                r_tx_valid <= 1'b1;
                r_tx_data  <= NAK_BYTE;
                r_error    <= 1'b1;
            end else if (w_go_done) begin
                r_state    <= DONE;
                r_tx_valid <= 1'b1;
                r_tx_data  <= ACK_BYTE;
            end
        end
    end

    axil_single_write #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (w_wr_start),
        .addr_i           (w_wr_addr),
        .data_i           (DATA_WIDTH'(w_word_next)),
        .busy_o           (w_wr_busy),
        .done_o           (w_wr_done),
        .err_o            (w_wr_err),
        .m_axil_awaddr_o  (m_axil_awaddr_o),
        .m_axil_awprot_o  (m_axil_awprot_o),
        .m_axil_awvalid_o (m_axil_awvalid_o),
        .m_axil_awready_i (m_axil_awready_i),
        .m_axil_wdata_o   (m_axil_wdata_o),
        .m_axil_wstrb_o   (m_axil_wstrb_o),
        .m_axil_wvalid_o  (m_axil_wvalid_o),
        .m_axil_wready_i  (m_axil_wready_i),
        .m_axil_bresp_i   (m_axil_bresp_i),
        .m_axil_bvalid_i  (m_axil_bvalid_i),
        .m_axil_bready_o  (m_axil_bready_o)
    );

    assign tx_valid_o = r_tx_valid;
    assign tx_data_o  = r_tx_data;
    assign core_rst_o = r_core_rst;
    assign error_o    = r_error;
    assign busy_o     = (r_state == ADDR) || (r_state == LEN) ||
                        (r_state == DATA) || w_wr_busy;

endmodule
